// File: rtl/uart_tx_cfg.sv
// UART transmitter: programmable baud divider, parity (none/even/odd), 1/2 stop bits, FIFO input.
// First start bit one clock after a push into an idle, empty queue; s_ready_o drops while the FIFO is full.

// Generic synchronous FIFO; registered occupancy count, head word visible while rd_vld_o is high.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_vld_i,
  output logic                         wr_rdy_o,
  input  logic [WIDTH-1:0]             wr_dat_i,
  output logic                         rd_vld_o,
  input  logic                         rd_rdy_i,
  output logic [WIDTH-1:0]             rd_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    cnt_q;
  logic             push, pop;

  assign wr_rdy_o = (cnt_q != LW'(DEPTH));
  assign rd_vld_o = (cnt_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign level_o  = cnt_q;
  assign push     = wr_vld_i && wr_rdy_o;
  assign pop      = rd_rdy_i && rd_vld_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DIV_WIDTH-1:0]              cfg_div_i,
  input  logic [1:0]                        cfg_parity_i,
  input  logic                              cfg_stop2_i,
  input  logic [DATA_BITS-1:0]              s_data_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  output logic                              serial_out_o,
  output logic                              tx_active_o,
  output logic                              tx_done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] div;
    logic [1:0]           parity;
    logic                 stop2;
  } cfg_t;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop2nd_q, stop2nd_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  cfg_t                 cfg_q, cfg_d, cfg_now;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 fifo_vld, pop, load, bit_end;
  logic [DATA_BITS-1:0] fifo_dat;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_vld_i (s_valid_i),
    .wr_rdy_o (s_ready_o),
    .wr_dat_i (s_data_i),
    .rd_vld_o (fifo_vld),
    .rd_rdy_i (pop),
    .rd_dat_o (fifo_dat),
    .level_o  (fifo_level_o)
  );

  // A divider of zero is stored as one so the bit timer never needs a special case.
  always_comb begin
    cfg_now.div    = (cfg_div_i == '0) ? DIV_WIDTH'(1) : cfg_div_i;
    cfg_now.parity = cfg_parity_i;
    cfg_now.stop2  = cfg_stop2_i;
  end

  function automatic logic par_en(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  assign bit_end = (cnt_q == cfg_q.div - DIV_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DIV_WIDTH'(1);
    bit_idx_d = bit_idx_q;
    stop2nd_d = stop2nd_q;
    shift_d   = shift_q;
    cfg_d     = cfg_q;
    load      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        load  = fifo_vld;
      end
      START: if (bit_end) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = '0;
        if (bit_idx_q != LAST_BIT) begin
          bit_idx_d = bit_idx_q + BW'(1);
        end else begin
          state_d   = par_en(cfg_q.parity) ? PARITY : STOP;
          stop2nd_d = 1'b0;
        end
      end
      PARITY: if (bit_end) begin
        cnt_d     = '0;
        state_d   = STOP;
        stop2nd_d = 1'b0;
      end
      STOP: if (bit_end) begin
        cnt_d = '0;
        if (cfg_q.stop2 && !stop2nd_q) stop2nd_d = 1'b1;
        else if (fifo_vld)             load      = 1'b1;
        else                           state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_dat;
      cfg_d   = cfg_now;
      state_d = START;
    end

    // Outputs are derived from next state so they can be registered without a cycle of lag.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[bit_idx_d];
      PARITY:  serial_d = (cfg_d.parity == 2'b10) ? ~^shift_d : ^shift_d;
      default: serial_d = 1'b1;
    endcase
    active_d = (state_d != IDLE);
    done_d   = (state_d == STOP) && (cnt_d == cfg_d.div - DIV_WIDTH'(1)) &&
               (!cfg_d.stop2 || stop2nd_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      stop2nd_q <= 1'b0;
      shift_q   <= '0;
      cfg_q     <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      stop2nd_q <= stop2nd_d;
      shift_q   <= shift_d;
      cfg_q     <= cfg_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign serial_out_o = serial_q;
  assign tx_active_o  = active_q;
  assign tx_done_o    = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit build and a 5-bit build share clock, reset and config.
module tb_uart_tx_cfg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;

  logic [7:0] s_data8 = '0;
  logic       s_valid8 = 1'b0;
  logic       s_ready8, so8, act8, done8;
  logic [2:0] lvl8;

  logic [4:0] s_data5 = '0;
  logic       s_valid5 = 1'b0;
  logic       s_ready5, so5, act5, done5;
  logic [2:0] lvl5;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  w [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [59:0] ser_log;
  logic [15:0] cap;

  always #5 clk = ~clk;

  uart_tx_cfg dut8 (
    .clk(clk), .rst(rst), .cfg_div_i(cfg_div), .cfg_parity_i(cfg_parity),
    .cfg_stop2_i(cfg_stop2), .s_data_i(s_data8), .s_valid_i(s_valid8),
    .s_ready_o(s_ready8), .serial_out_o(so8), .tx_active_o(act8),
    .tx_done_o(done8), .fifo_level_o(lvl8)
  );

  uart_tx_cfg #(.DATA_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .cfg_div_i(cfg_div), .cfg_parity_i(cfg_parity),
    .cfg_stop2_i(cfg_stop2), .s_data_i(s_data5), .s_valid_i(s_valid5),
    .s_ready_o(s_ready5), .serial_out_o(so5), .tx_active_o(act5),
    .tx_done_o(done5), .fifo_level_o(lvl5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 1) begin s_data5 = d[4:0]; s_valid5 = 1'b1; end
    else          begin s_data8 = d;      s_valid8 = 1'b1; end
    @(negedge clk);
    s_valid5 = 1'b0;
    s_valid8 = 1'b0;
  endtask

  task automatic wait_start(input int sel, input string tag, input int maxc);
    logic found = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      if (((sel == 1) ? so5 : so8) == 1'b0) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_start"}, 32'(found), 32'd1);
  endtask

  // Called on the first start-bit cycle; returns on the cycle after the frame's last stop cycle.
  task automatic check_frame(input int sel, input string tag, input int nbits, input int div,
                             input logic [15:0] exp_vec, output logic [15:0] cap_o);
    int len = nbits * div;
    int errs = 0, act_err = 0, done_n = 0, done_at = -1;
    logic s, a, d;
    cap_o = '0;
    for (int k = 0; k < len; k++) begin
      s = (sel == 1) ? so5 : so8;
      a = (sel == 1) ? act5 : act8;
      d = (sel == 1) ? done5 : done8;
      if (k % div == 0) cap_o[k / div] = s;
      if (s !== exp_vec[k / div]) errs++;
      if (a !== 1'b1) act_err++;
      if (d === 1'b1) begin done_n++; done_at = k; end
      @(negedge clk);
    end
    chk({tag, "_bits"}, 32'(cap_o), 32'(exp_vec));
    chk({tag, "_bit_cycles"}, 32'(errs), 32'd0);
    chk({tag, "_active"}, 32'(act_err), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
    chk({tag, "_done_at"}, 32'(done_at), 32'(len - 1));
  endtask

  initial begin
    int i, act_cycles, dn, falls, full_lvl, max_lvl;
    logic prev_act;

    // Reset state
    @(negedge clk);
    chk("rst_serial", 32'(so8), 32'd1);
    chk("rst_active", 32'(act8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_level", 32'(lvl8), 32'd0);
    chk("rst_ready", 32'(s_ready8), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: div=4, 8N1, 0xA5; start bit one clock after the push
    push(0, 8'hA5);
    chk("t1_lat_idle", 32'(so8), 32'd1);
    @(negedge clk);
    chk("t1_lat_fall", 32'(so8), 32'd0);
    check_frame(0, "t1", 10, 4, 16'h034A, cap);
    chk("t1_end_serial", 32'(so8), 32'd1);
    chk("t1_end_active", 32'(act8), 32'd0);
    chk("t1_end_level", 32'(lvl8), 32'd0);

    // 2: div=2, 0x07 with even then odd parity
    cfg_div = 16'd2; cfg_parity = 2'b01;
    push(0, 8'h07);
    wait_start(0, "t2e", 5);
    check_frame(0, "t2e", 11, 2, 16'h060E, cap);
    chk("t2e_parity", 32'(cap[9]), 32'd1);
    cfg_parity = 2'b10;
    push(0, 8'h07);
    wait_start(0, "t2o", 5);
    check_frame(0, "t2o", 11, 2, 16'h040E, cap);
    chk("t2o_parity", 32'(cap[9]), 32'd0);

    // 3: div=1, six words back to back
    cfg_div = 16'd1; cfg_parity = 2'b00;
    i = 0; act_cycles = 0; dn = 0; falls = 0; full_lvl = -1; max_lvl = 0; prev_act = 1'b0;
    ser_log = '0;
    for (int c = 0; c < 200; c++) begin
      if (act8) begin
        if (act_cycles < 60) ser_log[act_cycles] = so8;
        act_cycles++;
      end
      if (prev_act && !act8) falls++;
      prev_act = act8;
      if (done8) dn++;
      if (int'(lvl8) > max_lvl) max_lvl = int'(lvl8);
      if (!s_ready8 && full_lvl < 0) full_lvl = int'(lvl8);
      if (i < 6 && s_ready8) begin s_data8 = w[i]; s_valid8 = 1'b1; i++; end
      else s_valid8 = 1'b0;
      if (i == 6 && falls == 1) break;
      @(negedge clk);
    end
    s_valid8 = 1'b0;
    chk("t3_pushed", 32'(i), 32'd6);
    chk("t3_ready_drop_lvl", 32'(full_lvl), 32'd4);
    chk("t3_max_lvl", 32'(max_lvl), 32'd4);
    chk("t3_active_cycles", 32'(act_cycles), 32'd60);
    chk("t3_active_falls", 32'(falls), 32'd1);
    chk("t3_done_pulses", 32'(dn), 32'd6);
    chk("t3_end_level", 32'(lvl8), 32'd0);
    for (int f = 0; f < 6; f++)
      chk($sformatf("t3_frame%0d", f),
          32'({ser_log[f*10+9], ser_log[f*10+1 +: 8], ser_log[f*10]}),
          32'({1'b1, w[f], 1'b0}));

    // 4: div=3, two stop bits; clearing stop2 mid-frame only affects the next frame
    cfg_div = 16'd3; cfg_stop2 = 1'b1;
    push(0, 8'h3C);
    push(0, 8'h81);
    wait_start(0, "t4a", 3);
    cfg_stop2 = 1'b0;
    check_frame(0, "t4a", 11, 3, 16'h0678, cap);
    check_frame(0, "t4b", 10, 3, 16'h0302, cap);
    chk("t4_end_active", 32'(act8), 32'd0);

    // 5: reset mid-DATA with two words queued
    cfg_div = 16'd4;
    push(0, 8'h00);
    push(0, 8'h11);
    push(0, 8'h22);
    repeat (6) @(negedge clk);
    chk("t5_pre_level", 32'(lvl8), 32'd2);
    chk("t5_pre_serial", 32'(so8), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_serial", 32'(so8), 32'd1);
    chk("t5_rst_level", 32'(lvl8), 32'd0);
    chk("t5_rst_active", 32'(act8), 32'd0);
    chk("t5_rst_ready", 32'(s_ready8), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_post_idle", 32'(so8), 32'd1);
    push(0, 8'h5A);
    wait_start(0, "t5", 5);
    check_frame(0, "t5", 10, 4, 16'h02B4, cap);
    repeat (3) @(negedge clk);
    chk("t5_quiet_serial", 32'(so8), 32'd1);
    chk("t5_quiet_level", 32'(lvl8), 32'd0);

    // 6: div=0 acts as 1; 5-bit build with parity over 5 bits
    cfg_div = 16'd0; cfg_parity = 2'b00;
    push(0, 8'hC3);
    wait_start(0, "t6a", 5);
    check_frame(0, "t6a", 10, 1, 16'h0386, cap);
    cfg_parity = 2'b10;
    push(1, 8'h13);
    wait_start(1, "t6b", 5);
    check_frame(1, "t6b", 8, 1, 16'h00A6, cap);
    cfg_div = 16'd2; cfg_parity = 2'b01;
    push(1, 8'h13);
    wait_start(1, "t6c", 5);
    check_frame(1, "t6c", 8, 2, 16'h00E6, cap);
    chk("t6c_parity", 32'(cap[6]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
